// File: rtl/rv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// rv_pipe_pkg
// Types and constants shared by the front-end pipeline stages.
//   RV_XLEN      : native datapath width of the pipeline.
//   NOP_INSTR    : canonical RISC-V NOP (addi x0, x0, 0), driven on empty slots.
//   fetch_pkt_t  : one fetched packet {instr, pc, pc_plus_4}.
//   nop_pkt()    : the packet presented to decode when nothing is valid.
// -----------------------------------------------------------------------------
package rv_pipe_pkg;

  localparam int          RV_XLEN   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [RV_XLEN-1:0] instr;
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] pc_plus_4;
  } fetch_pkt_t;

  // Bubble packet: NOP instruction with zeroed PC fields.
  function automatic fetch_pkt_t nop_pkt();
    fetch_pkt_t p;
    p.instr     = RV_XLEN'(NOP_INSTR);
    p.pc        = '0;
    p.pc_plus_4 = '0;
    return p;
  endfunction

endpackage

// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
// Fetch-to-decode decoupling queue. Buffers {instr, pc, pc_plus_4} packets
// from fetch and presents them in order to decode. Replaces a plain IF/ID
// register so a single-cycle decode hold does not bubble fetch.
//
// Ports
//   clk              : clock, rising edge.
//   reset            : asynchronous, active-low; clears control state only.
//   f_valid_in       : fetch presents a packet this cycle.
//   f_instr_in       : fetched instruction.
//   f_pc_in          : PC of f_instr_in.
//   f_pc_plus_4_in   : f_pc_in + 4.
//   f_stall_out      : to fetch; 1 = queue full, fetch holds its PC.
//   flush_in         : control-flow redirect; discard everything buffered.
//   d_valid_out      : head packet valid for decode.
//   d_instr_out      : head instruction, NOP when not valid.
//   d_pc_out         : head PC, 0 when not valid.
//   d_pc_plus_4_out  : head PC+4, 0 when not valid.
//   d_ready_in       : decode accepts the head this cycle.
//   count_out        : occupied entries (debug / perf).
//
// Handshake: on the fetch side a packet transfers on a rising edge where
// f_valid_in=1 and f_stall_out=0 (stall is the inverse of ready and depends
// only on registered count); on the decode side the head transfers on an edge
// where d_valid_out=1 and d_ready_in=1. flush_in overrides both: nothing
// transfers on a flush edge and the queue empties.
//
// XLEN must equal rv_pipe_pkg::RV_XLEN because storage uses fetch_pkt_t.
// DEPTH must be a power of 2 and >= 2 so pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module if_id_queue
  import rv_pipe_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     f_valid_in,
  input  logic [XLEN-1:0]          f_instr_in,
  input  logic [XLEN-1:0]          f_pc_in,
  input  logic [XLEN-1:0]          f_pc_plus_4_in,
  output logic                     f_stall_out,
  input  logic                     flush_in,
  output logic                     d_valid_out,
  output logic [XLEN-1:0]          d_instr_out,
  output logic [XLEN-1:0]          d_pc_out,
  output logic [XLEN-1:0]          d_pc_plus_4_out,
  input  logic                     d_ready_in,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Packet storage; deliberately not reset, outputs are masked when empty.
  fetch_pkt_t       mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  fetch_pkt_t wr_pkt;
  fetch_pkt_t head_pkt;

  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);

    // Push is gated by the registered full flag only, so a pop on a full
    // cycle does not open a slot until the next cycle (stall has no path
    // from d_ready_in).
    push = f_valid_in & ~full  & ~flush_in;
    pop  = d_ready_in & ~empty & ~flush_in;

    wr_pkt.instr     = f_instr_in;
    wr_pkt.pc        = f_pc_in;
    wr_pkt.pc_plus_4 = f_pc_plus_4_in;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush_in) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      // Simultaneous push and pop leaves count unchanged.
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential control (asynchronous active-low reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_pkt;
  end

  // ---------------------------------------------------------------------------
  // Outputs: head entry, forced to the bubble packet when empty so stale
  // storage contents never reach decode.
  // ---------------------------------------------------------------------------
  always_comb begin
    head_pkt = empty ? nop_pkt() : mem_q[rd_ptr_q];
  end

  assign d_valid_out     = ~empty;
  assign f_stall_out     = full;
  assign count_out       = count_q;
  assign d_instr_out     = head_pkt.instr;
  assign d_pc_out        = head_pkt.pc;
  assign d_pc_plus_4_out = head_pkt.pc_plus_4;

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int PKT_W = 3 * XLEN;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic            f_valid_in;
  logic [XLEN-1:0] f_instr_in, f_pc_in, f_pc_plus_4_in;
  logic            f_stall_out;
  logic            flush_in;
  logic            d_valid_out;
  logic [XLEN-1:0] d_instr_out, d_pc_out, d_pc_plus_4_out;
  logic            d_ready_in;
  logic [$clog2(DEPTH):0] count_out;

  if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .f_valid_in      (f_valid_in),
    .f_instr_in      (f_instr_in),
    .f_pc_in         (f_pc_in),
    .f_pc_plus_4_in  (f_pc_plus_4_in),
    .f_stall_out     (f_stall_out),
    .flush_in        (flush_in),
    .d_valid_out     (d_valid_out),
    .d_instr_out     (d_instr_out),
    .d_pc_out        (d_pc_out),
    .d_pc_plus_4_out (d_pc_plus_4_out),
    .d_ready_in      (d_ready_in),
    .count_out       (count_out)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: expected queue contents, packet = {instr, pc, pc_plus_4}
  // ---------------------------------------------------------------------------
  logic [PKT_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the model's view of the queue.
  task automatic check_all(input string tag);
    logic [PKT_W-1:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : {32'h0000_0013, 32'h0, 32'h0};
    check({tag, ".d_valid"}, XLEN'(d_valid_out), XLEN'(exp_q.size() != 0));
    check({tag, ".count"},   XLEN'(count_out),   XLEN'(exp_q.size()));
    check({tag, ".stall"},   XLEN'(f_stall_out), XLEN'(exp_q.size() == DEPTH));
    check({tag, ".instr"},   d_instr_out,     head[3*XLEN-1:2*XLEN]);
    check({tag, ".pc"},      d_pc_out,        head[2*XLEN-1:XLEN]);
    check({tag, ".pc4"},     d_pc_plus_4_out, head[XLEN-1:0]);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: called at a falling edge; applies inputs for the next rising
  // edge, advances the model, and checks at the following falling edge.
  // ---------------------------------------------------------------------------
  task automatic drive_cycle(input logic valid, input logic [XLEN-1:0] pc,
                             input logic ready, input logic flush,
                             input string tag);
    int size_before;
    f_valid_in     = valid;
    f_pc_in        = pc;
    f_pc_plus_4_in = pc + 32'd4;
    f_instr_in     = {pc[23:0], 8'h33} ^ 32'h5a00_0000;
    d_ready_in     = ready;
    flush_in       = flush;

    size_before = exp_q.size();
    if (!reset || flush) begin
      exp_q.delete();
    end else begin
      if (ready && size_before != 0) void'(exp_q.pop_front());
      if (valid && size_before < DEPTH)
        exp_q.push_back({f_instr_in, f_pc_in, f_pc_plus_4_in});
    end
    @(negedge clk);
    check_all(tag);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [XLEN-1:0] fpc;
    logic            v, r, fl;

    reset = 1'b0;
    f_valid_in = 1'b0; f_pc_in = '0; f_pc_plus_4_in = '0; f_instr_in = '0;
    d_ready_in = 1'b0; flush_in = 1'b0;

    // Reset held 3 cycles with fetch presenting a packet.
    @(negedge clk);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'h40, 1'b0, 1'b0, "reset");
    reset = 1'b1;

    // Streaming with decode always ready.
    drive_cycle(1'b1, 32'h0, 1'b1, 1'b0, "stream0");
    drive_cycle(1'b1, 32'h4, 1'b1, 1'b0, "stream1");
    drive_cycle(1'b1, 32'h8, 1'b1, 1'b0, "stream2");
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, "stream3");
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, "drain");

    // Backpressure: fill, third push refused while full, then drain.
    drive_cycle(1'b1, 32'h10, 1'b0, 1'b0, "bp_push10");
    drive_cycle(1'b1, 32'h14, 1'b0, 1'b0, "bp_push14");
    drive_cycle(1'b1, 32'h18, 1'b0, 1'b0, "bp_full18");
    drive_cycle(1'b1, 32'h18, 1'b1, 1'b0, "bp_pop10");   // full+pop: push ignored
    drive_cycle(1'b1, 32'h18, 1'b1, 1'b0, "bp_pop14");
    drive_cycle(1'b0, 32'h1c, 1'b1, 1'b0, "bp_pop18");
    drive_cycle(1'b0, 32'h1c, 1'b1, 1'b0, "bp_empty");

    // Flush while full with a concurrent push.
    drive_cycle(1'b1, 32'h20, 1'b0, 1'b0, "fl_push20");
    drive_cycle(1'b1, 32'h24, 1'b0, 1'b0, "fl_push24");
    drive_cycle(1'b1, 32'h28, 1'b1, 1'b1, "fl_flush");
    drive_cycle(1'b1, 32'h100, 1'b0, 1'b0, "fl_push100");
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, "fl_pop100");

    // Wrap-around: prime one entry, then 9 push/pop pairs.
    drive_cycle(1'b1, 32'h200, 1'b0, 1'b0, "wrap_prime");
    for (int i = 1; i <= 9; i++)
      drive_cycle(1'b1, 32'h200 + 32'(i * 4), 1'b1, 1'b0, "wrap");
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, "wrap_drain");

    // Asynchronous reset mid-operation while full.
    drive_cycle(1'b1, 32'h300, 1'b0, 1'b0, "ar_push0");
    drive_cycle(1'b1, 32'h304, 1'b0, 1'b0, "ar_push1");
    #2 reset = 1'b0;
    exp_q.delete();
    #1 check_all("async_rst");
    @(negedge clk);
    reset = 1'b1;
    drive_cycle(1'b1, 32'h400, 1'b0, 1'b0, "post_rst_push");

    // Randomized traffic with a fetch model that advances only on accept.
    fpc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      v  = ($urandom_range(0, 9) < 7);
      r  = ($urandom_range(0, 9) < 6);
      fl = ($urandom_range(0, 19) == 0);
      if (fl) begin
        drive_cycle(v, fpc, r, 1'b1, "rand_flush");
        fpc = {$urandom_range(0, 32'hffff), 2'b00};
      end else begin
        logic accept;
        accept = v && (exp_q.size() < DEPTH);
        drive_cycle(v, fpc, r, 1'b0, "rand");
        if (accept) fpc = fpc + 32'd4;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
